// File: rtl/lnvd_fft_sched.sv
// lnvd_fft_sched: captures one 4-channel sample set per strobe and serializes
// it (channel 0..3) onto a valid/ready stream for the shared FFT core.
// Words carry the channel number and frame start/end markers; sample sets
// that arrive while the previous set is still draining are dropped and
// recorded in a sticky overflow flag.
module lnvd_fft_sched #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         smp_valid,
    input  logic [DATA_W-1:0]            smp_in1,
    input  logic [DATA_W-1:0]            smp_in2,
    input  logic [DATA_W-1:0]            smp_in3,
    input  logic [DATA_W-1:0]            smp_in4,
    output logic                         smp_ready,
    output logic                         fft_valid,
    input  logic                         fft_ready,
    output logic [DATA_W-1:0]            fft_data,
    output logic [1:0]                   fft_ch,
    output logic                         fft_sof,
    output logic                         fft_eof,
    output logic                         overflow,
    input  logic                         overflow_clr,
    output logic [$clog2(FRAME_LEN)-1:0] smp_idx
);

    localparam int IDX_W = $clog2(FRAME_LEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [1:0]               ch_q, ch_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [3:0][DATA_W-1:0]   hold_q, hold_d;
    logic                     ovf_q, ovf_d;
    logic                     rdy_q, rdy_d;
    logic                     capture_s;
    logic                     drop_s;

    // Capture and drop qualifiers; smp_valid with enable low is ignored entirely.
    always_comb begin
        capture_s = smp_valid & rdy_q & enable;
        drop_s    = smp_valid & ~rdy_q & enable;
    end

    // Next-state logic: sequencing FSM, channel counter, sample index, holding register.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (capture_s) begin
                    hold_d  = {smp_in4, smp_in3, smp_in2, smp_in1};
                    ch_d    = 2'd0;
                    state_d = ST_SEND;
                end else if (!enable) begin
                    // Disabled idle restarts the frame so the next capture carries sof.
                    idx_d = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (fft_ready) begin
                    if (ch_q == 2'd3) begin
                        // Power-of-two frame length: natural wrap gives modulo FRAME_LEN.
                        idx_d   = idx_q + IDX_W'(1);
                        ch_d    = 2'd0;
                        state_d = ST_IDLE;
                    end else begin
                        ch_d = ch_q + 2'd1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = 2'd0;
            end
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // smp_ready is registered from the next state so it is low for all of SEND.
    always_comb begin
        rdy_d = (state_d == ST_IDLE) & enable;
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ch_q    <= 2'd0;
            idx_q   <= {IDX_W{1'b0}};
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    // Stream outputs decoded from registered state only (no path from fft_ready/smp_valid).
    always_comb begin
        fft_valid = 1'b0;
        fft_data  = {DATA_W{1'b0}};
        fft_ch    = 2'd0;
        fft_sof   = 1'b0;
        fft_eof   = 1'b0;
        if (state_q == ST_SEND) begin
            fft_valid = 1'b1;
            fft_data  = hold_q[ch_q];
            fft_ch    = ch_q;
            fft_sof   = (ch_q == 2'd0) & (idx_q == {IDX_W{1'b0}});
            fft_eof   = (ch_q == 2'd3) & (idx_q == IDX_W'(FRAME_LEN - 1));
        end else begin
            fft_valid = 1'b0;
        end
    end

    assign smp_ready = rdy_q;
    assign overflow  = ovf_q;
    assign smp_idx   = idx_q;

endmodule

// File: tb/tb_lnvd_fft_sched.sv
// Directed self-checking bench for lnvd_fft_sched, built with FRAME_LEN=4 so
// frame wrap, sof/eof and disable behaviour are reachable in a short run.
module tb_lnvd_fft_sched;

    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 4;
    localparam int IDX_W     = $clog2(FRAME_LEN);

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_in1, smp_in2, smp_in3, smp_in4;
    logic              smp_ready;
    logic              fft_valid;
    logic              fft_ready;
    logic [DATA_W-1:0] fft_data;
    logic [1:0]        fft_ch;
    logic              fft_sof;
    logic              fft_eof;
    logic              overflow;
    logic              overflow_clr;
    logic [IDX_W-1:0]  smp_idx;

    int n_checks = 0;
    int n_errors = 0;

    lnvd_fft_sched #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .smp_valid    (smp_valid),
        .smp_in1      (smp_in1),
        .smp_in2      (smp_in2),
        .smp_in3      (smp_in3),
        .smp_in4      (smp_in4),
        .smp_ready    (smp_ready),
        .fft_valid    (fft_valid),
        .fft_ready    (fft_ready),
        .fft_data     (fft_data),
        .fft_ch       (fft_ch),
        .fft_sof      (fft_sof),
        .fft_eof      (fft_eof),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .smp_idx      (smp_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one set with fft_ready=1 and check all four words plus the return to idle.
    task automatic send_set(input logic [11:0] d0, input logic [11:0] d1,
                            input logic [11:0] d2, input logic [11:0] d3, input int idx);
        logic [11:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        chk_eq("set_ready_before", {31'd0, smp_ready}, 32'd1);
        chk_eq("set_idx_before", {30'd0, smp_idx}, idx);
        smp_in1 = d0; smp_in2 = d1; smp_in3 = d2; smp_in4 = d3;
        smp_valid = 1'b1;
        step();
        smp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_eq("set_valid", {31'd0, fft_valid}, 32'd1);
            chk_eq("set_data", {20'd0, fft_data}, {20'd0, d[k]});
            chk_eq("set_ch", {30'd0, fft_ch}, k);
            chk_eq("set_sof", {31'd0, fft_sof}, (k == 0 && idx == 0) ? 32'd1 : 32'd0);
            chk_eq("set_eof", {31'd0, fft_eof}, (k == 3 && idx == 3) ? 32'd1 : 32'd0);
            chk_eq("set_ready_busy", {31'd0, smp_ready}, 32'd0);
            step();
        end
        chk_eq("set_idle_valid", {31'd0, fft_valid}, 32'd0);
        chk_eq("set_idle_ready", {31'd0, smp_ready}, 32'd1);
        chk_eq("set_idx_after", {30'd0, smp_idx}, (idx + 1) % FRAME_LEN);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; smp_valid = 1'b0; fft_ready = 1'b1;
        overflow_clr = 1'b0;
        smp_in1 = 12'h000; smp_in2 = 12'h000; smp_in3 = 12'h000; smp_in4 = 12'h000;

        // Reset state
        repeat (3) step();
        chk_eq("rst_ready", {31'd0, smp_ready}, 32'd0);
        chk_eq("rst_valid", {31'd0, fft_valid}, 32'd0);
        chk_eq("rst_data", {20'd0, fft_data}, 32'd0);
        chk_eq("rst_ch", {30'd0, fft_ch}, 32'd0);
        chk_eq("rst_sof", {31'd0, fft_sof}, 32'd0);
        chk_eq("rst_eof", {31'd0, fft_eof}, 32'd0);
        chk_eq("rst_ovf", {31'd0, overflow}, 32'd0);
        chk_eq("rst_idx", {30'd0, smp_idx}, 32'd0);
        rst_n = 1'b1;
        chk_eq("rel_ready_now", {31'd0, smp_ready}, 32'd0);
        step();
        chk_eq("rel_ready_next", {31'd0, smp_ready}, 32'd1);

        // Single set
        send_set(12'h111, 12'h222, 12'h333, 12'h444, 0);

        // Frame wrap: fresh reset, then 9 sets
        rst_n = 1'b0;
        #1;
        chk_eq("rst2_idx", {30'd0, smp_idx}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        for (int s = 0; s < 9; s++) begin
            send_set(12'h100 + 12'(s), 12'h200 + 12'(s), 12'h300 + 12'(s), 12'h400 + 12'(s),
                     s % FRAME_LEN);
        end

        // Back-pressure on ch2 with a colliding strobe (idx is 1 here)
        chk_eq("bp_ovf_pre", {31'd0, overflow}, 32'd0);
        smp_in1 = 12'hA01; smp_in2 = 12'hA02; smp_in3 = 12'hA03; smp_in4 = 12'hA04;
        smp_valid = 1'b1;
        step();
        smp_valid = 1'b0;
        chk_eq("bp_ch0", {30'd0, fft_ch}, 32'd0);
        step();
        chk_eq("bp_ch1", {30'd0, fft_ch}, 32'd1);
        step();
        fft_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_eq("bp_hold_valid", {31'd0, fft_valid}, 32'd1);
            chk_eq("bp_hold_ch", {30'd0, fft_ch}, 32'd2);
            chk_eq("bp_hold_data", {20'd0, fft_data}, 32'hA03);
            chk_eq("bp_ovf", {31'd0, overflow}, (i >= 4) ? 32'd1 : 32'd0);
            if (i == 3) begin
                smp_in1 = 12'hB01; smp_in2 = 12'hB02; smp_in3 = 12'hB03; smp_in4 = 12'hB04;
                smp_valid = 1'b1;
            end else begin
                smp_valid = 1'b0;
            end
            step();
        end
        fft_ready = 1'b1;
        chk_eq("bp_rel_data2", {20'd0, fft_data}, 32'hA03);
        step();
        chk_eq("bp_ch3", {30'd0, fft_ch}, 32'd3);
        chk_eq("bp_data3", {20'd0, fft_data}, 32'hA04);
        step();
        chk_eq("bp_idle_valid", {31'd0, fft_valid}, 32'd0);
        chk_eq("bp_idx", {30'd0, smp_idx}, 32'd2);

        // Clear colliding with a drop, then a clean clear (idx 2)
        smp_in1 = 12'hC01; smp_in2 = 12'hC02; smp_in3 = 12'hC03; smp_in4 = 12'hC04;
        smp_valid = 1'b1;
        step();
        chk_eq("clr_c0", {20'd0, fft_data}, 32'hC01);
        smp_valid = 1'b1;
        overflow_clr = 1'b1;
        step();
        smp_valid = 1'b0;
        overflow_clr = 1'b0;
        chk_eq("clr_vs_drop", {31'd0, overflow}, 32'd1);
        chk_eq("clr_c1", {20'd0, fft_data}, 32'hC02);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk_eq("clr_clean", {31'd0, overflow}, 32'd0);
        chk_eq("clr_c2", {20'd0, fft_data}, 32'hC03);
        step();
        chk_eq("clr_c3", {20'd0, fft_data}, 32'hC04);
        step();
        chk_eq("clr_idx", {30'd0, smp_idx}, 32'd3);

        // Disable mid-frame at idx 2
        send_set(12'hD01, 12'hD02, 12'hD03, 12'hD04, 3);
        send_set(12'hE01, 12'hE02, 12'hE03, 12'hE04, 0);
        send_set(12'hF01, 12'hF02, 12'hF03, 12'hF04, 1);
        smp_in1 = 12'h701; smp_in2 = 12'h702; smp_in3 = 12'h703; smp_in4 = 12'h704;
        smp_valid = 1'b1;
        step();
        smp_valid = 1'b0;
        chk_eq("dis_w0", {20'd0, fft_data}, 32'h701);
        enable = 1'b0;
        step();
        chk_eq("dis_w1", {20'd0, fft_data}, 32'h702);
        step();
        chk_eq("dis_w2", {20'd0, fft_data}, 32'h703);
        step();
        chk_eq("dis_w3", {20'd0, fft_data}, 32'h704);
        chk_eq("dis_w3_valid", {31'd0, fft_valid}, 32'd1);
        chk_eq("dis_no_eof", {31'd0, fft_eof}, 32'd0);
        step();
        chk_eq("dis_idle_valid", {31'd0, fft_valid}, 32'd0);
        chk_eq("dis_idle_ready", {31'd0, smp_ready}, 32'd0);
        chk_eq("dis_idx_pre", {30'd0, smp_idx}, 32'd3);
        smp_valid = 1'b1;
        step();
        smp_valid = 1'b0;
        chk_eq("dis_idx_zero", {30'd0, smp_idx}, 32'd0);
        chk_eq("dis_ignored_valid", {31'd0, fft_valid}, 32'd0);
        chk_eq("dis_ignored_ovf", {31'd0, overflow}, 32'd0);
        enable = 1'b1;
        step();
        send_set(12'h801, 12'h802, 12'h803, 12'h804, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
